slot_reels: RTL and testbench

Reel generator for the slot-machine datapath, directly upstream of the bank stage. On a spin request it animates four decimal reels and stops them one at a time using a free-running LFSR. It drives the four 4-bit reel values that the bank compares for a jackpot. While the reels are spinning, the outputs never present four equal values, so the bank cannot credit a false jackpot.

---
 rtl/slot_reels.sv | 146 ++++++++++++++
 tb/tb_slot_reels.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_reels.sv
// ============================================================================
// slot_reels : four decimal reels, LFSR-stopped one at a time on a spin edge
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module slot_reels #(
   parameter int          SPIN_TICKS    = 16,
   parameter int          STAGGER_TICKS = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spin,
   output logic [3:0] randNum1,
   output logic [3:0] randNum2,
   output logic [3:0] randNum3,
   output logic [3:0] randNum4,
   output logic       busy,
   output logic [3:0] locked,
   output logic       result_valid
);

   localparam int MAX_TICKS = (SPIN_TICKS > STAGGER_TICKS) ? SPIN_TICKS : STAGGER_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);
   localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_TICKS - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_TICKS - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SPIN = 2'd1, S_STOP = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0][3:0] reel_q, reel_d;
   logic [3:0]      locked_q, locked_d;
   logic            busy_q, busy_d;
   logic            rv_q, rv_d;
   logic [15:0]     lfsr_q;
   logic            spin_q;
   logic            spin_rise;

   function automatic logic [3:0] inc10(input logic [3:0] v);
      return (v == 4'd9) ? 4'd0 : v + 4'd1;
   endfunction

   function automatic logic [3:0] red10(input logic [3:0] n);
      return (n >= 4'd10) ? n - 4'd10 : n;
   endfunction

   assign spin_rise = spin & ~spin_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
         spin_q <= 1'b0;
      end else begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
         spin_q <= spin;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reel_d   = reel_q;
      locked_d = locked_q;
      busy_d   = busy_q;
      rv_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (spin_rise) begin
               state_d  = S_SPIN;
               cnt_d    = '0;
               locked_d = 4'b0000;
               reel_d   = {4'd3, 4'd2, 4'd1, 4'd0};
               busy_d   = 1'b1;
            end
         end
         S_SPIN: begin
            for (int k = 0; k < 4; k++) reel_d[k] = inc10(reel_q[k]);
            if (cnt_q == SPIN_LAST) begin
               reel_d[0]   = red10(lfsr_q[3:0]);
               locked_d[0] = 1'b1;
               state_d     = S_STOP;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            for (int k = 0; k < 4; k++)
               if (!locked_q[k]) reel_d[k] = inc10(reel_q[k]);
            if (cnt_q == STAG_LAST) begin
               cnt_d = '0;
               for (int k = 1; k < 4; k++) begin
                  if (locked_q[k-1] && !locked_q[k]) begin
                     reel_d[k]   = red10(lfsr_q[4*k +: 4]);
                     locked_d[k] = 1'b1;
                  end
               end
               if (locked_q[2]) begin
                  busy_d  = 1'b0;
                  rv_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            // Last spinning reel would complete a match: step it once more.
            if (locked_d == 4'b0111 && reel_d[0] == reel_d[1] &&
                reel_d[1] == reel_d[2] && reel_d[3] == reel_d[0])
               reel_d[3] = inc10(reel_d[3]);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         reel_q   <= {4'd3, 4'd2, 4'd1, 4'd0};
         locked_q <= 4'b0000;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reel_q   <= reel_d;
         locked_q <= locked_d;
         busy_q   <= busy_d;
         rv_q     <= rv_d;
      end
   end

   assign randNum1     = reel_q[0];
   assign randNum2     = reel_q[1];
   assign randNum3     = reel_q[2];
   assign randNum4     = reel_q[3];
   assign locked       = locked_q;
   assign busy         = busy_q;
   assign result_valid = rv_q;

endmodule

`default_nettype wire

// File: tb/tb_slot_reels.sv
// ============================================================================
// tb_slot_reels : directed timing table plus random spins against a model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_slot_reels;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spin_v [2];
   logic [3:0] dr [2][4];
   logic [3:0] dl [2];
   logic       db [2];
   logic       dv [2];

   int n_chk  = 0;
   int n_fail = 0;
   int jackpots = 0;

   always #5 clk = ~clk;

   slot_reels #(.SPIN_TICKS(4), .STAGGER_TICKS(2), .LFSR_SEED(16'hACE1)) dut_a (
      .clk(clk), .rst(rst), .spin(spin_v[0]),
      .randNum1(dr[0][0]), .randNum2(dr[0][1]), .randNum3(dr[0][2]), .randNum4(dr[0][3]),
      .busy(db[0]), .locked(dl[0]), .result_valid(dv[0]));

   slot_reels #(.SPIN_TICKS(1), .STAGGER_TICKS(1), .LFSR_SEED(16'h1234)) dut_b (
      .clk(clk), .rst(rst), .spin(spin_v[1]),
      .randNum1(dr[1][0]), .randNum2(dr[1][1]), .randNum3(dr[1][2]), .randNum4(dr[1][3]),
      .busy(db[1]), .locked(dl[1]), .result_valid(dv[1]));

   // Reference model: time since acceptance decides when each reel stops.
   int          SPN  [2] = '{4, 1};
   int          STG  [2] = '{2, 1};
   logic [15:0] SEED [2] = '{16'hACE1, 16'h1234};
   logic [15:0] m_lfsr [2];
   bit          m_spq [2], m_busy [2], m_rv [2];
   int          m_t [2];
   int          m_reel [2][4];
   bit   [3:0]  m_lock [2];

   function automatic void model_reset(int i);
      m_lfsr[i] = SEED[i];
      m_spq[i] = 0; m_busy[i] = 0; m_rv[i] = 0; m_t[i] = 0; m_lock[i] = 4'b0000;
      for (int k = 0; k < 4; k++) m_reel[i][k] = k;
   endfunction

   function automatic void model_step(int i);
      logic [15:0] old = m_lfsr[i];
      bit rise = spin_v[i] && !m_spq[i];
      m_lfsr[i] = (old >> 1) ^ (old[0] ? 16'hB400 : 16'h0000);
      m_spq[i]  = spin_v[i];
      m_rv[i]   = 0;
      if (!m_busy[i]) begin
         if (rise) begin
            m_busy[i] = 1; m_t[i] = 0; m_lock[i] = 4'b0000;
            for (int k = 0; k < 4; k++) m_reel[i][k] = k;
         end
      end else begin
         m_t[i]++;
         for (int k = 0; k < 4; k++) begin
            if (!m_lock[i][k]) begin
               if (m_t[i] == SPN[i] + k*STG[i]) begin
                  m_reel[i][k] = int'((old >> (4*k)) & 16'hF) % 10;
                  m_lock[i][k] = 1;
               end else begin
                  m_reel[i][k] = (m_reel[i][k] + 1) % 10;
               end
            end
         end
         if (m_lock[i] == 4'b0111 && m_reel[i][0] == m_reel[i][1] &&
             m_reel[i][1] == m_reel[i][2] && m_reel[i][3] == m_reel[i][0])
            m_reel[i][3] = (m_reel[i][3] + 1) % 10;
         if (m_lock[i] == 4'b1111) begin
            m_busy[i] = 0; m_rv[i] = 1;
         end
      end
   endfunction

   task automatic check(int i);
      bit ok, eq4, bad;
      ok = (db[i] == m_busy[i]) && (dv[i] == m_rv[i]) && (dl[i] == m_lock[i]);
      for (int k = 0; k < 4; k++) ok = ok && (int'(dr[i][k]) == m_reel[i][k]);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL model_cmp dut%0d @%0t: got reels=%0d,%0d,%0d,%0d lk=%b busy=%b rv=%b; expected reels=%0d,%0d,%0d,%0d lk=%b busy=%b rv=%b",
                  i, $time, dr[i][0], dr[i][1], dr[i][2], dr[i][3], dl[i], db[i], dv[i],
                  m_reel[i][0], m_reel[i][1], m_reel[i][2], m_reel[i][3], m_lock[i], m_busy[i], m_rv[i]);
      end
      eq4 = (dr[i][0] == dr[i][1]) && (dr[i][1] == dr[i][2]) && (dr[i][2] == dr[i][3]);
      bad = (db[i] && eq4);
      for (int k = 0; k < 4; k++) bad = bad || (dr[i][k] > 4'd9);
      n_chk++;
      if (bad) begin
         n_fail++;
         $display("FAIL guard dut%0d @%0t: reels=%0d,%0d,%0d,%0d busy=%b; required range 0..9 and no four-equal while busy",
                  i, $time, dr[i][0], dr[i][1], dr[i][2], dr[i][3], db[i]);
      end
      if (dv[i] && eq4) jackpots++;
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check(i);
   endtask

   typedef struct {
      bit       sp;
      bit [3:0] lk;
      bit       bz;
      bit       rv;
   } vec_t;
   vec_t tbl [12];

   initial begin
      int rv_seen;
      tbl[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 4'b0000, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 4'b0001, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 4'b0001, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 4'b0011, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 4'b0011, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 4'b0111, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 4'b0111, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 4'b1111, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 4'b1111, 1'b0, 1'b0};

      spin_v[0] = 1'b0; spin_v[1] = 1'b0;
      rst = 1'b1;
      model_reset(0); model_reset(1);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) check(i);
      n_chk++;
      if (dut_a.lfsr_q !== 16'hACE1) begin
         n_fail++;
         $display("FAIL reset_lfsr: got %h, expected ACE1", dut_a.lfsr_q);
      end
      rst = 1'b0;

      // Lock timing, second spin edge mid-spin, then spin held high.
      repeat (3) tick();
      for (int n = 0; n < 12; n++) begin
         spin_v[0] = tbl[n].sp;
         tick();
         n_chk++;
         if (dl[0] !== tbl[n].lk || db[0] !== tbl[n].bz || dv[0] !== tbl[n].rv) begin
            n_fail++;
            $display("FAIL timing[%0d]: got lk=%b busy=%b rv=%b, expected lk=%b busy=%b rv=%b",
                     n, dl[0], db[0], dv[0], tbl[n].lk, tbl[n].bz, tbl[n].rv);
         end
      end
      for (int n = 0; n < 100; n++) begin
         tick();
         n_chk++;
         if (db[0] !== 1'b0 || dv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL held_spin[%0d]: got busy=%b rv=%b, expected 0 0", n, db[0], dv[0]);
         end
      end

      // Reset between edges E+5 and E+6 of a running spin.
      spin_v[0] = 1'b0; tick();
      spin_v[0] = 1'b1; tick();
      repeat (5) tick();
      rst = 1'b1;
      #1;
      model_reset(0); model_reset(1);
      for (int i = 0; i < 2; i++) check(i);
      n_chk++;
      if (dr[0][0] !== 4'd0 || dr[0][1] !== 4'd1 || dr[0][2] !== 4'd2 || dr[0][3] !== 4'd3 || db[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midspin_reset: got reels=%0d,%0d,%0d,%0d busy=%b, expected 0,1,2,3 busy=0",
                  dr[0][0], dr[0][1], dr[0][2], dr[0][3], db[0]);
      end
      #2 rst = 1'b0;
      rv_seen = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (dv[0]) rv_seen++;
      end
      n_chk++;
      if (rv_seen != 1) begin
         n_fail++;
         $display("FAIL post_reset_spin: got %0d result_valid pulses, expected 1", rv_seen);
      end

      // Random spin requests on both instances.
      for (int n = 0; n < 60000; n++) begin
         spin_v[0] = 1'($urandom_range(0, 1));
         spin_v[1] = 1'($urandom_range(0, 1));
         tick();
      end
      n_chk++;
      if (jackpots == 0) begin
         n_fail++;
         $display("FAIL jackpot_seen: got %0d genuine four-of-a-kind results, expected at least 1", jackpots);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
